pipeline_hazard_controller: RTL and testbench

//  Central sequencer for the 5-stage SPARC-subset pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_hazard_controller_pkg.sv | 43 ++++
 rtl/pipeline_hazard_controller_fwd_select.sv | 24 ++
 rtl/pipeline_hazard_controller.sv | 162 ++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller:
// forwarding/PC select encodings, sequencer state and scoreboard entry layout.
package pipeline_hazard_controller_pkg;

    // Register-address width carried by scoreboard entries; the top's REG_W must match it.
    localparam int SB_RD_W = 5;

    typedef enum logic [1:0] {
        SEL_RF  = 2'b00,
        SEL_EX  = 2'b01,
        SEL_MEM = 2'b10,
        SEL_WB  = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        PCSEL_NPC = 2'b00,
        PCSEL_TA  = 2'b01,
        PCSEL_ALU = 2'b10
    } pc_sel_t;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic [SB_RD_W-1:0] rd;
        logic               we;
        logic               load;
        logic               dm;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{rd: '0, we: 1'b0, load: 1'b0, dm: 1'b0};

    // An in-flight result can feed an ID operand only if it is really written,
    // really read, and not r0 (hard-wired zero).
    function automatic logic src_hit(input sb_entry_t e,
                                     input logic [SB_RD_W-1:0] src,
                                     input logic used);
        return used && e.we && (e.rd != '0) && (e.rd == src);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_fwd_select.sv
// Forwarding source select for one ID operand: youngest matching producer wins.
module pipeline_hazard_controller_fwd_select
    import pipeline_hazard_controller_pkg::*;
(
    input  logic [SB_RD_W-1:0] src,
    input  logic               used,
    input  sb_entry_t          ex_entry,
    input  sb_entry_t          mem_entry,
    input  sb_entry_t          wb_entry,
    output logic [1:0]         sel
);

    always_comb begin
        sel = SEL_RF;
        if (src_hit(ex_entry, src, used)) begin
            sel = SEL_EX;
        end else if (src_hit(mem_entry, src, used)) begin
            sel = SEL_MEM;
        end else if (src_hit(wb_entry, src, used)) begin
            sel = SEL_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the 5-stage pipeline: destination scoreboard, operand forwarding,
// load-use bubble, PC redirect / delay-slot annul and data-memory wait freeze.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_W   = SB_RD_W,
    parameter int DM_WAIT = 0,
    parameter int CNT_W   = 3
) (
    input  logic             Clk,
    input  logic             R,
    input  logic [REG_W-1:0] ID_RA,
    input  logic [REG_W-1:0] ID_RB,
    input  logic [REG_W-1:0] ID_RDataIn,
    input  logic             ID_uses_ra,
    input  logic             ID_uses_rb,
    input  logic             ID_uses_rdi,
    input  logic [REG_W-1:0] ID_RD_MUX,
    input  logic             ID_RF_enable,
    input  logic             ID_load_instr,
    input  logic             ID_DataMem_enable,
    input  logic             ID_B_instr,
    input  logic             ID_29_a,
    input  logic             ID_ba_instr,
    input  logic             ID_Call_instr,
    input  logic             BranchCondition_Out,
    input  logic             EX_jmpl_instr,
    output logic             PC_LE,
    output logic             nPC_LE,
    output logic             IFID_LE,
    output logic             Pipe_LE,
    output logic             S,
    output logic             IFID_Reset,
    output logic [1:0]       MUX_IF_Signal,
    output logic [1:0]       Sig_DataHazard_EX,
    output logic [1:0]       Sig_DataHazard_MEM,
    output logic [1:0]       Sig_DataHazard_WB
);

    localparam int NUM_SRC = 3;

    sb_entry_t        id_entry;
    sb_entry_t        ex_reg;
    sb_entry_t        mem_reg;
    sb_entry_t        wb_reg;
    hz_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Operand slots: 0 = PA (rs1), 1 = PB (rs2), 2 = DataIn (store rd).
    logic [NUM_SRC-1:0][REG_W-1:0] src_addr;
    logic [NUM_SRC-1:0]            src_used;
    logic [NUM_SRC-1:0][1:0]       src_sel;
    logic [NUM_SRC-1:0]            src_load_hit;

    logic    in_wait;
    logic    load_use;
    logic    annul;
    logic    front_le;
    logic    pipe_le;
    logic    bubble;
    logic    ifid_clear;
    pc_sel_t pc_sel;

    assign src_addr = {ID_RDataIn, ID_RB, ID_RA};
    assign src_used = {ID_uses_rdi, ID_uses_rb, ID_uses_ra};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            pipeline_hazard_controller_fwd_select u_fwd (
                .src       (src_addr[gi]),
                .used      (src_used[gi]),
                .ex_entry  (ex_reg),
                .mem_entry (mem_reg),
                .wb_entry  (wb_reg),
                .sel       (src_sel[gi])
            );
            assign src_load_hit[gi] = ex_reg.load && src_hit(ex_reg, src_addr[gi], src_used[gi]);
        end
    endgenerate

    always_comb begin
        id_entry      = SB_EMPTY;
        id_entry.rd   = ID_RD_MUX;
        id_entry.we   = ID_RF_enable;
        id_entry.load = ID_load_instr;
        id_entry.dm   = ID_DataMem_enable;
    end

    assign in_wait  = (state_reg == ST_MEM_WAIT);
    assign load_use = |src_load_hit;
    // ba,a annuls its delay slot even though the branch is always taken.
    assign annul    = ID_B_instr && ID_29_a && (!BranchCondition_Out || ID_ba_instr);

    always_comb begin
        front_le   = 1'b1;
        pipe_le    = 1'b1;
        bubble     = 1'b0;
        ifid_clear = 1'b0;
        pc_sel     = PCSEL_NPC;
        if (in_wait) begin
            front_le = 1'b0;
            pipe_le  = 1'b0;
        end else begin
            if (EX_jmpl_instr) begin
                pc_sel = PCSEL_ALU;
            end else if (ID_Call_instr || (ID_B_instr && BranchCondition_Out)) begin
                pc_sel = PCSEL_TA;
            end
            bubble     = load_use;
            front_le   = !load_use;
            ifid_clear = annul && !load_use;
        end
    end

    // While R is high every output shows its reset value regardless of state.
    assign PC_LE              = R | front_le;
    assign nPC_LE             = R | front_le;
    assign IFID_LE            = R | front_le;
    assign Pipe_LE            = R | pipe_le;
    assign S                  = R | bubble;
    assign IFID_Reset         = R | ifid_clear;
    assign MUX_IF_Signal      = R ? PCSEL_NPC : pc_sel;
    assign Sig_DataHazard_EX  = R ? SEL_RF : src_sel[0];
    assign Sig_DataHazard_MEM = R ? SEL_RF : src_sel[1];
    assign Sig_DataHazard_WB  = R ? SEL_RF : src_sel[2];

    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            ex_reg    <= SB_EMPTY;
            mem_reg   <= SB_EMPTY;
            wb_reg    <= SB_EMPTY;
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else begin
            if (pipe_le) begin
                ex_reg  <= bubble ? SB_EMPTY : id_entry;
                mem_reg <= ex_reg;
                wb_reg  <= mem_reg;
            end
            case (state_reg)
                ST_RUN: begin
                    // The entry about to enter MEM decides whether memory needs extra cycles.
                    if ((DM_WAIT > 0) && ex_reg.dm) begin
                        state_reg <= ST_MEM_WAIT;
                        cnt_reg   <= CNT_W'(DM_WAIT);
                    end
                end
                ST_MEM_WAIT: begin
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= ST_RUN;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench for pipeline_hazard_controller (DM_WAIT=2): the driver queues
// hand-computed output vectors, a monitor compares them one cycle at a time.
module tb_pipeline_hazard_controller;

    logic       Clk = 1'b0;
    logic       R   = 1'b1;
    logic [4:0] ID_RA = '0, ID_RB = '0, ID_RDataIn = '0, ID_RD_MUX = '0;
    logic       ID_uses_ra = 0, ID_uses_rb = 0, ID_uses_rdi = 0;
    logic       ID_RF_enable = 0, ID_load_instr = 0, ID_DataMem_enable = 0;
    logic       ID_B_instr = 0, ID_29_a = 0, ID_ba_instr = 0, ID_Call_instr = 0;
    logic       BranchCondition_Out = 0, EX_jmpl_instr = 0;
    logic       PC_LE, nPC_LE, IFID_LE, Pipe_LE, S, IFID_Reset;
    logic [1:0] MUX_IF_Signal, Sig_DataHazard_EX, Sig_DataHazard_MEM, Sig_DataHazard_WB;

    logic [11:0] act;
    logic [11:0] exp_q[$];
    string       name_q[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic        rst_val = 1'b1;

    always #5 Clk = ~Clk;

    pipeline_hazard_controller #(
        .REG_W   (5),
        .DM_WAIT (2),
        .CNT_W   (3)
    ) dut (
        .Clk                 (Clk),
        .R                   (R),
        .ID_RA               (ID_RA),
        .ID_RB               (ID_RB),
        .ID_RDataIn          (ID_RDataIn),
        .ID_uses_ra          (ID_uses_ra),
        .ID_uses_rb          (ID_uses_rb),
        .ID_uses_rdi         (ID_uses_rdi),
        .ID_RD_MUX           (ID_RD_MUX),
        .ID_RF_enable        (ID_RF_enable),
        .ID_load_instr       (ID_load_instr),
        .ID_DataMem_enable   (ID_DataMem_enable),
        .ID_B_instr          (ID_B_instr),
        .ID_29_a             (ID_29_a),
        .ID_ba_instr         (ID_ba_instr),
        .ID_Call_instr       (ID_Call_instr),
        .BranchCondition_Out (BranchCondition_Out),
        .EX_jmpl_instr       (EX_jmpl_instr),
        .PC_LE               (PC_LE),
        .nPC_LE              (nPC_LE),
        .IFID_LE             (IFID_LE),
        .Pipe_LE             (Pipe_LE),
        .S                   (S),
        .IFID_Reset          (IFID_Reset),
        .MUX_IF_Signal       (MUX_IF_Signal),
        .Sig_DataHazard_EX   (Sig_DataHazard_EX),
        .Sig_DataHazard_MEM  (Sig_DataHazard_MEM),
        .Sig_DataHazard_WB   (Sig_DataHazard_WB)
    );

    assign act = {PC_LE, nPC_LE, IFID_LE, Pipe_LE, S, IFID_Reset, MUX_IF_Signal,
                  Sig_DataHazard_EX, Sig_DataHazard_MEM, Sig_DataHazard_WB};

    // Expected vector: fe = PC/nPC/IFID load enable, ple = Pipe_LE, s = bubble, ifr = IFID_Reset.
    function automatic logic [11:0] ev(input logic fe, input logic ple, input logic s,
                                       input logic ifr, input logic [1:0] mux,
                                       input logic [1:0] pa, input logic [1:0] pb,
                                       input logic [1:0] di);
        return {fe, fe, fe, ple, s, ifr, mux, pa, pb, di};
    endfunction

    // use3 = {ra,rb,rdi}; wr = {rf,load,dm}; ctl = {b,a,ba,call,cond,jmpl}
    task automatic step(input string nm, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] rdi, input logic [2:0] use3, input logic [4:0] rd,
                        input logic [2:0] wr, input logic [5:0] ctl, input logic [11:0] e);
        @(posedge Clk);
        #1;
        R          = rst_val;
        ID_RA      = ra;
        ID_RB      = rb;
        ID_RDataIn = rdi;
        ID_RD_MUX  = rd;
        {ID_uses_ra, ID_uses_rb, ID_uses_rdi} = use3;
        {ID_RF_enable, ID_load_instr, ID_DataMem_enable} = wr;
        {ID_B_instr, ID_29_a, ID_ba_instr, ID_Call_instr, BranchCondition_Out, EX_jmpl_instr} = ctl;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        logic [11:0] e;
        string       n;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                vec_cnt++;
                if (act !== e) begin
                    err_cnt++;
                    $display("FAIL %s: got %b required %b (LE3 PLE S IFR MUX PA PB DI)", n, act, e);
                end else begin
                    $display("ok   %s: %b", n, act);
                end
            end
        end
    end

    initial begin : driver
        // Reset held for four cycles with busy inputs; outputs must show reset values.
        for (int i = 0; i < 4; i++)
            step($sformatf("reset_%0d", i), 5'd1, 5'd1, 5'd1, 3'b111, 5'd1, 3'b100, 6'b110111,
                 ev(1, 1, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00));
        rst_val = 1'b0;
        step("post_reset_empty_sb", 5'd1, 5'd1, 5'd0, 3'b110, 5'd0, 3'b000, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));

        // Forwarding EX -> MEM -> WB and priority.
        step("add_r1",          5'd2, 5'd3, 5'd0, 3'b110, 5'd1, 3'b100, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
        step("sub_r2_r1_r1_ex", 5'd1, 5'd1, 5'd0, 3'b110, 5'd2, 3'b100, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00));
        step("r1_from_mem",     5'd1, 5'd2, 5'd1, 3'b101, 5'd0, 3'b000, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10));
        step("r1_wb_r2_mem",    5'd1, 5'd2, 5'd0, 3'b110, 5'd0, 3'b000, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b11, 2'b10, 2'b00));
        step("r2_wb_wr_r2",     5'd2, 5'd0, 5'd0, 3'b100, 5'd2, 3'b100, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b11, 2'b00, 2'b00));
        step("r2_ex_wr_r2",     5'd2, 5'd0, 5'd0, 3'b100, 5'd2, 3'b100, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00));
        step("prio_ex_over_mem",5'd2, 5'd0, 5'd0, 3'b100, 5'd0, 3'b000, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00));
        step("prio_mem_over_wb",5'd2, 5'd0, 5'd0, 3'b100, 5'd0, 3'b000, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00));

        // r0 is never forwarded.
        step("write_r0",        5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 3'b100, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
        for (int i = 0; i < 3; i++)
            step($sformatf("read_r0_%0d", i), 5'd0, 5'd0, 5'd0, 3'b111, 5'd0, 3'b000, 6'b0,
                 ev(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));

        // Load-use: one bubble, then the load moving into MEM freezes for two cycles.
        step("ld_r3",           5'd4, 5'd0, 5'd0, 3'b100, 5'd3, 3'b111, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
        step("add_r4_r3_stall", 5'd3, 5'd5, 5'd0, 3'b110, 5'd4, 3'b100, 6'b0, ev(0, 1, 1, 0, 2'b00, 2'b01, 2'b00, 2'b00));
        step("ld_memwait_1",    5'd3, 5'd5, 5'd0, 3'b110, 5'd4, 3'b100, 6'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00));
        step("ld_memwait_2",    5'd3, 5'd5, 5'd0, 3'b110, 5'd4, 3'b100, 6'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00));
        step("add_r4_fwd_mem",  5'd3, 5'd5, 5'd0, 3'b110, 5'd4, 3'b100, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00));
        step("r3_wb_r4_ex",     5'd3, 5'd4, 5'd0, 3'b110, 5'd0, 3'b000, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b11, 2'b01, 2'b00));

        // Store wait: two frozen cycles, scoreboard held, then RUN.
        step("st_r3_r4",        5'd4, 5'd0, 5'd3, 3'b101, 5'd3, 3'b001, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00));
        step("add_r5_r4_wb",    5'd4, 5'd0, 5'd0, 3'b100, 5'd5, 3'b100, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b11, 2'b00, 2'b00));
        step("st_wait_1",       5'd5, 5'd4, 5'd0, 3'b110, 5'd0, 3'b000, 6'b000001, ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00));
        step("st_wait_2",       5'd5, 5'd4, 5'd0, 3'b110, 5'd0, 3'b000, 6'b000001, ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00));
        step("st_wait_done",    5'd5, 5'd4, 5'd0, 3'b110, 5'd0, 3'b000, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00));

        // Redirect and annul.
        step("bne_a_not_taken", 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 6'b110000, ev(1, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00));
        step("bne_a_taken",     5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 6'b110010, ev(1, 1, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00));
        step("ba_a",            5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 6'b111010, ev(1, 1, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00));
        step("call",            5'd0, 5'd0, 5'd0, 3'b000, 5'd15, 3'b100, 6'b000100, ev(1, 1, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00));
        step("bne_no_annul",    5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 6'b100000, ev(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
        step("jmpl_in_ex",      5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 6'b000001, ev(1, 1, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00));
        step("jmpl_over_call",  5'd0, 5'd0, 5'd0, 3'b000, 5'd15, 3'b100, 6'b000101, ev(1, 1, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00));
        step("ld_r6_r15_ex",    5'd15, 5'd0, 5'd0, 3'b100, 5'd6, 3'b111, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00));
        step("annul_in_stall",  5'd6, 5'd0, 5'd0, 3'b100, 5'd0, 3'b000, 6'b110000, ev(0, 1, 1, 0, 2'b00, 2'b01, 2'b00, 2'b00));
        step("annul_memwait_1", 5'd6, 5'd0, 5'd0, 3'b100, 5'd0, 3'b000, 6'b110000, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00));
        step("annul_memwait_2", 5'd6, 5'd0, 5'd0, 3'b100, 5'd0, 3'b000, 6'b110000, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00));
        step("annul_after_wait",5'd6, 5'd0, 5'd0, 3'b100, 5'd0, 3'b000, 6'b110000, ev(1, 1, 0, 1, 2'b00, 2'b10, 2'b00, 2'b00));
        step("nop_final",       5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 6'b0, ev(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));

        repeat (3) @(negedge Clk);
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
